y86_mc_core: RTL and testbench
==============================

# y86_mc_core

Parametrised multicycle y86-subset CPU core, the next generation of the single-phase-ring sequential core. It adds a `bus_ready` memory handshake with unbounded wait states and a parametrised data, address and reset-vector configuration. It has a retired-instruction counter and a clean halt/illegal-opcode stop with no simulator `$finish`. It sits between the testbench/system memory model and the fault-analysis harness, which observes `current_opcode`, `halted`, `illegal` and `instret`.

## Interface
- `DW`, 32: register/data width; must be ≥ 32. The instruction word is `bus_in[31:0]`.
- `AW`, 32: address width of `bus_A` and IP.
- `RESET_IP`, 0: IP value loaded on reset.
- `CW`, 16: width of the retired-instruction counter.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `bus_A` output AW: memory address.
- `bus_in` input DW: read data.
- `bus_out` output DW: write data (store data register).
- `bus_RE` output 1: read request.
- `bus_WE` output 1: write request.
- `bus_ready` input 1: memory completes the current request in this cycle.
- `current_opcode` output 8: `IR[7:0]`.
- `halted` output 1: core stopped (halt or illegal).
- `illegal` output 1: stopped on an undecodable instruction.
- `instret` output CW: instructions retired, modulo 2^CW.

## Operation
- Fields:
  - opcode = `IR[7:0]`; mod = `IR[15:14]`; RS = `IR[13:11]`; RD = `IR[10:8]`.
  - distance = sext(`IR[15:8]`); disp = sext(`IR[23:16]`), both to DW.
- Register file: 8 × DW.
- Instructions:
  - load: 0x8B, mod=1, 3 bytes. `R[RS] ← mem[R[6]+disp]`.
  - store: 0x89, mod=1, 3 bytes. `mem[R[6]+disp] ← R[RS]`.
  - move: 0x89, mod=3, 2 bytes. `R[RD] ← R[RS]`.
  - add: 0x01, 2 bytes. `R[RD] ← R[RD]+R[RS]`; sets ZF.
  - sub: 0x29, 2 bytes. `R[RD] ← R[RD]+~R[RS]+1`; sets ZF.
  - jnez: 0x75, 2 bytes. IP += 2 + (ZF ? 0 : distance).
  - halt: 0xF4, 1 byte.
- Any other opcode, or 0x89/0x8B with any other mod, is illegal.
- States and transitions:
  - FETCH: `bus_A`=IP, `bus_RE`=1. When `bus_ready`=1, IR ← `bus_in[31:0]` and go to DECODE; otherwise stay.
  - DECODE:
    - A ← R[memory ? 6 : RD]; B ← R[RS].
    - halt → HALT with `halted`=1, IP unchanged, no retire.
    - illegal → HALT with `halted`=1 and `illegal`=1.
    - Otherwise IP ← IP + length + (taken ? distance : 0), truncated to AW (wraps), then go to EXEC.
  - EXEC:
    - ALUout = A + (memory ? disp : sub ? ~B : B) + sub, width DW.
    - MAR ← ALUout[AW-1:0]; C ← move ? B : ALUout; MDRw ← B.
    - ZF ← (ALUout==0) only for add/sub. Go to MEM.
  - MEM:
    - load: `bus_A`=MAR, `bus_RE`=1; on `bus_ready`, MDRr ← `bus_in` and go to WB.
    - store: `bus_A`=MAR, `bus_WE`=1; on `bus_ready`, go to WB.
    - Other instructions go to WB unconditionally; `bus_RE`=`bus_WE`=0.
  - WB:
    - load writes R[RS] ← MDRr; add/sub/move write R[RD] ← C; store and jnez write nothing.
    - `instret` += 1 (wraps). Go to FETCH.
  - HALT: terminal; no bus activity; only `rst` exits.
- `bus_A` = 0 when neither request is asserted.
- `bus_RE` and `bus_WE` are never asserted together.

## Timing
- Reset values (asynchronous, applied immediately):
  - state FETCH, IP=`RESET_IP`, R[0..7]=0, ZF=0, IR=0, A/B/C/MAR/MDRw/MDRr=0, `instret`=0.
  - `halted`=0, `illegal`=0, `bus_WE`=0, `bus_out`=0, `current_opcode`=0.
  - `bus_RE`=1 with `bus_A`=`RESET_IP` (fetch is requested from the first cycle).
- Outputs are combinational from state and registers; `bus_ready` is sampled at the rising edge.
- Latency with zero wait states: 5 cycles per instruction (FETCH, DECODE, EXEC, MEM, WB). Each wait cycle in FETCH or in the load/store MEM phase adds 1 cycle.
- A request holds `bus_A`, `bus_RE`/`bus_WE` and `bus_out` stable until the `bus_ready` cycle.
- `bus_ready` outside FETCH and load/store MEM is ignored.
- Reset during a pending request deasserts `bus_WE` at once and discards all in-flight state.
- jnez uses the ZF value from the previous add/sub; ZF is retained across move, load, store and jnez.
- `halted` rises 2 cycles after the halt fetch completes (the cycle after DECODE) and stays high.

## Test plan
- Reset then straight-line code with `bus_ready`=1:
  - Program: `mov` 0x89 0xC8 (R0←R1=0), `add` 0x01 0x00, halt.
  - Required: each instruction takes exactly 5 cycles, `instret`=2, `halted`=1, ZF=1, `illegal`=0.
- Wait states:
  - `bus_ready` low for 3 cycles on each fetch and on a load with R6=0x100, disp=0x04, mem[0x104]=0xDEADBEEF.
  - Required: `bus_A` held at 0x104 for 4 cycles; R[RS]=0xDEADBEEF; the instruction takes 11 cycles.
- Store then load round trip:
  - R1=0x12345678, R6=0x200, store disp=0xFC (−4), then load into R2 with the same disp.
  - Required: `bus_WE` with `bus_A`=0x1FC and `bus_out`=0x12345678; then R2=0x12345678.
- jnez loop:
  - R0=3, R1=1, loop `sub` R0,R1 ; jnez −4.
  - Required: branch taken twice, falls through when R0=0; final IP = loop end; `instret`=6 on exit.
- Illegal opcode 0xFF (and separately 0x89 with mod=0):
  - Required: `halted`=`illegal`=1, IP unchanged, `instret` unchanged, no further `bus_RE`.
- Asynchronous reset asserted mid-store wait state with `RESET_IP`=0x40:
  - Required: `bus_WE` drops in the same cycle, `bus_A`=0x40, `bus_RE`=1, registers cleared, and fetch restarts after `rst` falls.

Source files
------------

// File: rtl/y86_mc_core.sv
// y86_mc_core: multicycle y86-subset CPU core with a ready-handshaked memory bus.
// Each instruction walks FETCH -> DECODE -> EXEC -> MEM -> WB. Fetch and load/store
// phases stall until bus_ready. Halt and illegal opcodes park the core in HALT
// until reset.
module y86_mc_core #(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_IP = '0,
  parameter int            CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] bus_A,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_RE,
  output logic          bus_WE,
  input  logic          bus_ready,
  output logic [7:0]    current_opcode,
  output logic          halted,
  output logic          illegal,
  output logic [CW-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_next;

  // Architectural and internal registers. Only the low three instruction bytes
  // are ever decoded, so the top byte of the fetched word is not kept.
  logic [AW-1:0] ip;
  logic [23:0]   ir;
  logic [DW-1:0] regs [8];
  logic          zf;
  logic [DW-1:0] a, b, c, mdrw, mdrr;
  logic [AW-1:0] mar;
  logic          illegal_q;
  logic [CW-1:0] instret_q;

  // Instruction fields and decode
  logic [7:0]    opcode;
  logic [1:0]    mod;
  logic [2:0]    rs, rd;
  logic          is_load, is_store, is_move, is_add, is_sub, is_jnez, is_halt;
  logic          is_mem, is_legal, taken;
  logic [AW-1:0] dist_aw;
  logic [DW-1:0] disp_dw;
  logic [1:0]    len;
  logic [AW-1:0] ip_next;
  logic [DW-1:0] alu_b, alu_out;

  assign opcode  = ir[7:0];
  assign mod     = ir[15:14];
  assign rs      = ir[13:11];
  assign rd      = ir[10:8];
  assign dist_aw = {{(AW-8){ir[15]}}, ir[15:8]};
  assign disp_dw = {{(DW-8){ir[23]}}, ir[23:16]};

  // Decode the opcode/mod pair into one-hot instruction classes and the next IP
  always_comb begin
    is_load  = (opcode == 8'h8B) && (mod == 2'd1);
    is_store = (opcode == 8'h89) && (mod == 2'd1);
    is_move  = (opcode == 8'h89) && (mod == 2'd3);
    is_add   = (opcode == 8'h01);
    is_sub   = (opcode == 8'h29);
    is_jnez  = (opcode == 8'h75);
    is_halt  = (opcode == 8'hF4);
    is_mem   = is_load || is_store;
    is_legal = is_load || is_store || is_move || is_add || is_sub || is_jnez || is_halt;
    taken    = is_jnez && !zf;
    len      = 2'd2;
    if (is_mem) len = 2'd3;
    else if (is_halt) len = 2'd1;
    ip_next  = ip + AW'(len) + (taken ? dist_aw : '0);
  end

  // Shared adder: effective address for memory ops, add/sub result otherwise
  always_comb begin
    alu_b = b;
    if (is_mem) alu_b = disp_dw;
    else if (is_sub) alu_b = ~b;
    alu_out = a + alu_b + DW'(is_sub);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state logic; bus_ready only matters while a request is outstanding
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (bus_ready) state_next = S_DECODE;
      S_DECODE: state_next = (is_halt || !is_legal) ? S_HALT : S_EXEC;
      S_EXEC:   state_next = S_MEM;
      S_MEM:    if (!is_mem || bus_ready) state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Bus request outputs; the address is forced to zero when idle
  always_comb begin
    bus_A  = '0;
    bus_RE = 1'b0;
    bus_WE = 1'b0;
    case (state)
      S_FETCH: begin
        bus_A  = ip;
        bus_RE = 1'b1;
      end
      S_MEM: begin
        if (is_load) begin
          bus_A  = mar;
          bus_RE = 1'b1;
        end else if (is_store) begin
          bus_A  = mar;
          bus_WE = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, register file and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip        <= RESET_IP;
      ir        <= '0;
      zf        <= 1'b0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      mar       <= '0;
      mdrw      <= '0;
      mdrr      <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (bus_ready) ir <= bus_in[23:0];
        S_DECODE: begin
          a <= regs[is_mem ? 3'd6 : rd];
          b <= regs[rs];
          if (!is_legal) illegal_q <= 1'b1;
          else if (!is_halt) ip <= ip_next;
        end
        S_EXEC: begin
          mar  <= AW'(alu_out);
          c    <= is_move ? b : alu_out;
          mdrw <= b;
          if (is_add || is_sub) zf <= (alu_out == '0);
        end
        S_MEM: if (is_load && bus_ready) mdrr <= bus_in;
        S_WB: begin
          if (is_load) regs[rs] <= mdrr;
          else if (is_add || is_sub || is_move) regs[rd] <= c;
          instret_q <= instret_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus_out        = mdrw;
  assign current_opcode = opcode;
  assign halted         = (state == S_HALT);
  assign illegal        = illegal_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_y86_mc_core.sv
// tb_y86_mc_core: directed programs against a byte-addressed memory model with
// programmable wait states. Expected bus transactions are queued up front and a
// monitor pops and compares them as the core completes each request.
module tb_y86_mc_core;

  logic        clk;
  logic        rst;
  logic [31:0] bus_A;
  logic [31:0] bus_in;
  logic [31:0] bus_out;
  logic        bus_RE;
  logic        bus_WE;
  logic        bus_ready;
  logic [7:0]  current_opcode;
  logic        halted;
  logic        illegal;
  logic [15:0] instret;

  y86_mc_core #(
    .DW(32), .AW(32), .RESET_IP(32'h40), .CW(16)
  ) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_in(bus_in), .bus_out(bus_out),
    .bus_RE(bus_RE), .bus_WE(bus_WE), .bus_ready(bus_ready),
    .current_opcode(current_opcode), .halted(halted), .illegal(illegal),
    .instret(instret)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          done_cyc[$];
  logic [7:0]  mem [1024];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wait_states = 0;
  int          wait_cnt = 0;
  int          hold_cnt = 0;
  int          pc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd32(input logic [31:0] a);
    return {mem[a[9:0] + 10'd3], mem[a[9:0] + 10'd2], mem[a[9:0] + 10'd1], mem[a[9:0]]};
  endfunction

  task automatic put32(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) mem[a[9:0] + 10'(i)] = d[8*i +: 8];
  endtask

  task automatic emit(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    logic [23:0] w;
    w = {b2, b1, b0};
    for (int i = 0; i < n; i++) mem[pc + i] = w[8*i +: 8];
    pc = pc + n;
  endtask

  task automatic expect_rd(input logic [31:0] a);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: decides bus_ready and read data half a cycle ahead of the edge
  initial begin
    bus_ready = 1'b0;
    bus_in    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_ready = 1'b0;
        wait_cnt  = 0;
        bus_in    = '0;
      end else if (bus_RE || bus_WE) begin
        bus_in = bus_RE ? rd32(bus_A) : 32'h0;
        if (wait_cnt >= wait_states) begin
          bus_ready = 1'b1;
          wait_cnt  = 0;
          if (bus_WE) put32(bus_A, bus_out);
        end else begin
          bus_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Monitor: every completed request is popped against the expected queue
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (bus_RE && bus_A == 32'h104) hold_cnt++;
        if (bus_ready && (bus_RE || bus_WE)) begin
          done_cyc.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL bus_txn: unexpected re=%0b we=%0b addr=%h data=%h, expected none",
                     bus_RE, bus_WE, bus_A, bus_out);
          end else begin
            e = exp_q.pop_front();
            if ((bus_RE == bus_WE) || (bus_WE != e.wr) || (bus_A != e.addr) ||
                (e.wr && bus_out != e.data)) begin
              failures++;
              $display("[TB] FAIL bus_txn: got re=%0b we=%0b addr=%h data=%h, expected we=%0b addr=%h data=%h",
                       bus_RE, bus_WE, bus_A, bus_out, e.wr, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Hold reset, wipe memory and queues, point the assembler at the reset vector
  task automatic begin_test();
    rst = 1'b1;
    exp_q.delete();
    done_cyc.delete();
    hold_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    pc = 32'h40;
  endtask

  // Release reset away from any clock edge with the chosen wait-state count
  task automatic applyStimulus(input int ws);
    wait_states = ws;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic run_until_halt(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!halted && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_halted"}, {31'h0, halted}, 32'h1);
    checkOutput({name, "_all_txns_seen"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    rst = 1'b1;

    // Straight-line code, zero wait states: mov R0<-R1 ; add R0,R0 ; halt
    begin_test();
    emit(8'h89, 8'hC8, 8'h00, 2);
    emit(8'h01, 8'h00, 8'h00, 2);
    emit(8'hF4, 8'h00, 8'h00, 1);
    expect_rd(32'h40); expect_rd(32'h42); expect_rd(32'h44);
    #1;
    checkOutput("reset_bus_RE", {31'h0, bus_RE}, 32'h1);
    checkOutput("reset_bus_A", bus_A, 32'h40);
    checkOutput("reset_bus_WE", {31'h0, bus_WE}, 32'h0);
    checkOutput("reset_bus_out", bus_out, 32'h0);
    checkOutput("reset_flags", {current_opcode, 6'h0, halted, illegal, instret}, 32'h0);
    applyStimulus(0);
    repeat (4) @(posedge clk);
    #1 checkOutput("t1_instret_edge4", instret, 32'h0);
    @(posedge clk);
    #1 checkOutput("t1_instret_edge5", instret, 32'h1);
    repeat (5) @(posedge clk);
    #1 checkOutput("t1_instret_edge10", instret, 32'h2);
    @(posedge clk);
    #1 checkOutput("t1_halted_edge11", {31'h0, halted}, 32'h0);
    @(posedge clk);
    #1 checkOutput("t1_halted_edge12", {31'h0, halted}, 32'h1);
    checkOutput("t1_illegal", {31'h0, illegal}, 32'h0);
    checkOutput("t1_zf", {31'h0, dut.zf}, 32'h1);
    checkOutput("t1_instret_final", instret, 32'h2);
    checkOutput("t1_opcode", current_opcode, 32'hF4);
    run_until_halt("t1", 4);

    // Wait states: 3 idle cycles per request; load R3 <- mem[R6+4] with R6=0x100
    begin_test();
    put32(32'h60, 32'h100);
    put32(32'h104, 32'hDEADBEEF);
    emit(8'h8B, 8'h70, 8'h60, 3);
    emit(8'h8B, 8'h58, 8'h04, 3);
    emit(8'h89, 8'h58, 8'h08, 3);
    emit(8'hF4, 8'h00, 8'h00, 1);
    expect_rd(32'h40); expect_rd(32'h60);
    expect_rd(32'h43); expect_rd(32'h104);
    expect_rd(32'h46); expect_wr(32'h108, 32'hDEADBEEF);
    expect_rd(32'h49);
    applyStimulus(3);
    run_until_halt("t2", 200);
    checkOutput("t2_addr_hold", hold_cnt, 32'h4);
    if (done_cyc.size() >= 5) checkOutput("t2_load_cycles", done_cyc[4] - done_cyc[2], 32'd11);
    else checkOutput("t2_load_cycles_txn_count", done_cyc.size(), 32'd7);
    checkOutput("t2_instret", instret, 32'h3);

    // Store/load round trip with a negative displacement and one wait state
    begin_test();
    put32(32'h64, 32'h12345678);
    put32(32'h68, 32'h200);
    emit(8'h8B, 8'h48, 8'h64, 3);
    emit(8'h8B, 8'h70, 8'h68, 3);
    emit(8'h89, 8'h48, 8'hFC, 3);
    emit(8'h8B, 8'h50, 8'hFC, 3);
    emit(8'h89, 8'h50, 8'h00, 3);
    emit(8'hF4, 8'h00, 8'h00, 1);
    expect_rd(32'h40); expect_rd(32'h64);
    expect_rd(32'h43); expect_rd(32'h68);
    expect_rd(32'h46); expect_wr(32'h1FC, 32'h12345678);
    expect_rd(32'h49); expect_rd(32'h1FC);
    expect_rd(32'h4C); expect_wr(32'h200, 32'h12345678);
    expect_rd(32'h4F);
    applyStimulus(1);
    run_until_halt("t3", 200);
    checkOutput("t3_r2", dut.regs[2], 32'h12345678);
    checkOutput("t3_instret", instret, 32'h5);

    // jnez loop: R0=3, R1=1 ; L: sub R0,R1 ; jnez L ; halt
    begin_test();
    put32(32'h6C, 32'h3);
    put32(32'h70, 32'h1);
    emit(8'h8B, 8'h40, 8'h6C, 3);
    emit(8'h8B, 8'h48, 8'h70, 3);
    emit(8'h29, 8'h08, 8'h00, 2);
    emit(8'h75, 8'hFC, 8'h00, 2);
    emit(8'hF4, 8'h00, 8'h00, 1);
    expect_rd(32'h40); expect_rd(32'h6C);
    expect_rd(32'h43); expect_rd(32'h70);
    for (int i = 0; i < 3; i++) begin
      expect_rd(32'h46);
      expect_rd(32'h48);
    end
    expect_rd(32'h4A);
    applyStimulus(0);
    run_until_halt("t4", 200);
    checkOutput("t4_instret_2_loads_plus_6_loop", instret, 32'h8);
    checkOutput("t4_final_ip", dut.ip, 32'h4A);
    checkOutput("t4_r0", dut.regs[0], 32'h0);
    checkOutput("t4_zf", {31'h0, dut.zf}, 32'h1);

    // Illegal opcodes after one retired move: 0xFF, then 0x89 with mod=0
    for (int k = 0; k < 2; k++) begin
      begin_test();
      emit(8'h89, 8'hC8, 8'h00, 2);
      if (k == 0) emit(8'hFF, 8'h00, 8'h00, 1);
      else        emit(8'h89, 8'h08, 8'h00, 2);
      expect_rd(32'h40); expect_rd(32'h42);
      applyStimulus(0);
      run_until_halt("t5", 100);
      repeat (8) @(posedge clk);
      #1;
      checkOutput("t5_illegal", {31'h0, illegal}, 32'h1);
      checkOutput("t5_halted", {31'h0, halted}, 32'h1);
      checkOutput("t5_instret", instret, 32'h1);
      checkOutput("t5_ip_unchanged", dut.ip, 32'h42);
      checkOutput("t5_no_bus", {bus_A[29:0], bus_RE, bus_WE}, 32'h0);
    end

    // Reset asserted while a store is stalled in wait states
    begin_test();
    put32(32'h64, 32'h12345678);
    emit(8'h8B, 8'h48, 8'h64, 3);
    emit(8'h89, 8'h48, 8'h10, 3);
    emit(8'hF4, 8'h00, 8'h00, 1);
    expect_rd(32'h40); expect_rd(32'h64);
    expect_rd(32'h43); expect_wr(32'h10, 32'h12345678);
    applyStimulus(4);
    begin
      int n;
      n = 0;
      while (!bus_WE && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("t6_store_pending", {31'h0, bus_WE}, 32'h1);
    end
    checkOutput("t6_bus_out_pending", bus_out, 32'h12345678);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_rst_bus_WE", {31'h0, bus_WE}, 32'h0);
    checkOutput("t6_rst_bus_RE", {31'h0, bus_RE}, 32'h1);
    checkOutput("t6_rst_bus_A", bus_A, 32'h40);
    checkOutput("t6_rst_bus_out", bus_out, 32'h0);
    checkOutput("t6_rst_r1", dut.regs[1], 32'h0);
    checkOutput("t6_rst_instret", instret, 32'h0);
    checkOutput("t6_store_not_done", rd32(32'h10), 32'h0);
    exp_q.delete();
    expect_rd(32'h40); expect_rd(32'h64);
    expect_rd(32'h43); expect_wr(32'h10, 32'h12345678);
    expect_rd(32'h46);
    wait_states = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    run_until_halt("t6", 100);
    checkOutput("t6_instret", instret, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
